// File: rtl/lsu_seq.sv
// lsu_seq: runs one MEM-stage load/store over a req/gnt/rvalid data bus, 3-cycle minimum latency.
// Holds the pipeline via stall_o while a transfer is outstanding; no request queuing.
package core;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;
endpackage

module lsu_seq #(
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  input  core::mem_op_t req_op_i,
  input  logic [31:0]   req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          req_ready_o,
  output logic          stall_o,
  output logic          resp_valid_o,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_err_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i
);
  localparam int unsigned CW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, RESP} state_t;

  state_t        r_state, w_next;
  core::mem_op_t r_op;
  logic [1:0]    r_lane;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [3:0]    r_be;
  logic          r_we, r_err;
  logic [CW-1:0] r_cnt;

  logic          w_legal, w_store, w_misal, w_accept, w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_load;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  always_comb begin
    w_legal = 1'b0;
    w_store = 1'b0;
    w_misal = 1'b0;
    case (req_op_i)
      core::MEM_LB, core::MEM_LBU: w_legal = 1'b1;
      core::MEM_LH, core::MEM_LHU: begin
        w_legal = 1'b1;
        w_misal = req_addr_i[0];
      end
      core::MEM_LW: begin
        w_legal = 1'b1;
        w_misal = |req_addr_i[1:0];
      end
      core::MEM_SB: begin
        w_legal = 1'b1;
        w_store = 1'b1;
      end
      core::MEM_SH: begin
        w_legal = 1'b1;
        w_store = 1'b1;
        w_misal = req_addr_i[0];
      end
      core::MEM_SW: begin
        w_legal = 1'b1;
        w_store = 1'b1;
        w_misal = |req_addr_i[1:0];
      end
      default: ;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && req_valid_i && w_legal;
  assign w_timeout = (r_cnt == CW'(GNT_TIMEOUT - 1));

  // Store data is replicated across lanes so the bus slave only needs the byte enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    case (req_op_i)
      core::MEM_SB: begin
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      core::MEM_SH: begin
        w_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      core::MEM_SW: w_wdata = req_wdata_i;
      default: ;
    endcase
  end

  always_comb begin
    w_byte = 8'(dmem_rdata_i >> {r_lane, 3'b000});
    w_half = r_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    w_load = '0;
    case (r_op)
      core::MEM_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      core::MEM_LBU: w_load = {24'b0, w_byte};
      core::MEM_LH:  w_load = {{16{w_half[15]}}, w_half};
      core::MEM_LHU: w_load = {16'b0, w_half};
      core::MEM_LW:  w_load = dmem_rdata_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op    <= core::MEM_NOP;
      r_lane  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= req_op_i;
            r_lane  <= req_addr_i[1:0];
            r_addr  <= {req_addr_i[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_we    <= w_store;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= w_misal;
          end
        end
        WAIT_GNT: begin
          if (!dmem_gnt_i) begin
            r_cnt <= r_cnt + 1'b1;
            r_err <= w_timeout;
          end
        end
        WAIT_RVALID: begin
          if (dmem_rvalid_i) begin
            r_rdata <= r_we ? '0 : w_load;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready_o  = 1'b0;
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = w_accept;
        if (w_accept) begin
          w_next = w_misal ? RESP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        stall_o      = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_we_o    = r_we;
        dmem_addr_o  = r_addr;
        dmem_be_o    = r_be;
        dmem_wdata_o = r_wdata;
        // A grant on the last allowed cycle still wins over the timeout.
        if (dmem_gnt_i) begin
          w_next = WAIT_RVALID;
        end else if (w_timeout) begin
          w_next = RESP;
        end
      end
      WAIT_RVALID: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          w_next = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = r_rdata;
        resp_err_o   = r_err;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (rst_i) begin
      w_next       = IDLE;
      req_ready_o  = 1'b1;
      stall_o      = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_be_o    = '0;
      dmem_wdata_o = '0;
    end
  end

endmodule
